alu_ex: RTL and testbench
=========================

# alu_ex

Execution stage directly downstream of the reservation station. It accepts one issued arithmetic/compare/JALR operation per cycle on the RS `ari_*` lines and computes the 32-bit result. It broadcasts `{ROB index, value}` on the common result bus that feeds RS, LSB and ROB wake-up/commit logic. The output is registered, so the stage is pipelined, and it is flushed on a mispredicted jump.

## Interface
Parameters:
- `RESULT_LAT`, 1 (2 when `ALU_MUL_EN` defined): issue-to-broadcast latency in cycles; derived, not overridable.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  global ready; when low the stage freezes.
- `jp_wrong`  in  1  branch mispredict flush.
- `ari_ins_flag`  in  1  RS issues an op this cycle.
- `ari_insty`  in  `ILEN`  internal opcode code from the shared defines.
- `ari_val1`, `ari_val2`  in  `RLEN`  operands; `val2` is already imm for I-type and JALR.
- `ari_ROB_idx`  in  `RBID`  destination ROB entry.
- `val_flag_RS`  out  1  result valid on broadcast bus.
- `val_idx_RS`  out  `RBID`  ROB index of result.
- `val_RS`  out  `RLEN`  result value.

## Operation
- An issue is accepted only when `ari_ins_flag && rdy && !jp_wrong && !rst`. RS frees its slot under the same condition, so no back-pressure exists and none is needed.
- ADD/ADDI: `val1+val2`. SUB: `val1-val2`. Results are mod 2^32.
- Logic ops: AND/OR/XOR and their I-type forms, bitwise.
- SLL/SRL/SRA and their I-type forms: shift amount is `val2[4:0]`; SRA is arithmetic.
- SLT/SLTI compare signed. SLTU/SLTIU compare unsigned. Result is 32'd1 or 32'd0.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: `val_RS` = 32'd1 if the branch condition holds, else 32'd0. The ROB resolves the target and mispredict.
- JALR: `val_RS = (val1+val2) & ~32'd1`, the jump target.
- Unknown opcode: broadcast with `val_RS` = 0. The valid flag is still raised so the ROB entry cannot hang.
- Stage register: `valid`, `idx` and `value` drive the `val_*_RS` outputs directly, with no combinational path from the inputs.

## Timing
- Reset (async): `val_flag_RS`=0, `val_idx_RS`=0, `val_RS`=0, and all internal stage valids are 0.
- Without `ALU_MUL_EN`: an op accepted at edge N is visible on the bus from N until N+1, i.e. exactly one cycle later. `val_flag_RS` is high for exactly one cycle per op.
- `jp_wrong` at an edge: all stage valids are cleared on that edge and any same-cycle issue is discarded. `val_flag_RS` is 0 for the following cycle.
- With `rdy` low: all stage registers hold, including a high `val_flag_RS`. Consumers also ignore the bus while `rdy` is low, so no result is lost or duplicated.
- Back-to-back issues produce back-to-back broadcasts with no bubble.
- When reset deasserts mid-stream, the first accepted op is the first one broadcast.

## Configuration
- `ALU_MUL_EN` defined:
  - Adds MUL/MULH/MULHSU/MULHU (RV32M), implemented with a two-stage multiplier.
  - Every op then uses a uniform 2-stage pipeline (stage1: operands/partial products; stage2: result register), so results never collide on the single bus.
  - Latency is 2 for all ops.
  - `jp_wrong` clears both stage valids.
- `ALU_MUL_EN` undefined:
  - Single stage, latency 1.
  - M-opcodes are treated as unknown (result 0).

## Structure
- Opcode codes, `ILEN`, `RLEN` and `RBID` stay in the shared defines header. The M-extension opcode codes are added there, guarded by nothing, so the decoder can reference them.
- Sub-module `alu_mul`, instantiated only under `ALU_MUL_EN`:
  - Inputs: `clk`, `rst`, `rdy`, `flush`, operands and a 2-bit signedness/high-half select.
  - Output: a 32-bit product one edge after capture.

## Test plan
- Reset asserted asynchronously mid-cycle -> outputs are 0 immediately. After release, ADD 5+7 idx 3 -> `val_flag_RS`=1, idx 3, val 12 one cycle later (two with the macro).
- SRA 0x80000000 by `val2`=0x24 (amount 4) -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT 1 vs 0xFFFFFFFF -> 0.
- BGE -1 vs 0 -> val 0; BGEU -1 vs 0 -> val 1; JALR `val1`=0x1001, `val2`=4 -> 0x1004.
- Issue on 3 consecutive cycles with idx 1, 2, 3 -> 3 consecutive broadcasts in order with no gaps. Then `jp_wrong` on the edge after the 2nd issue -> only idx 1 is broadcast (without the macro, idx 1 and 2).
- `rdy` low for 4 cycles while a result is valid -> outputs are held constant. When `rdy` rises, the flag drops after one cycle unless a new issue arrives.
- With `ALU_MUL_EN`: MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 2 -> 1; both appear 2 cycles after issue.

Source files
------------

// File: rtl/alu_ex_pkg.sv
// alu_ex_pkg: shared opcode codes, bus widths and the ALU evaluation helpers
// for the alu_ex execution stage. Optional build macro: ALU_MUL_EN (adds RV32M).
package alu_ex_pkg;

   localparam int ILEN = 6;
   localparam int RLEN = 32;
   localparam int RBID = 4;

`ifdef ALU_MUL_EN
   localparam int RESULT_LAT = 2;
`else
   localparam int RESULT_LAT = 1;
`endif

   localparam logic [ILEN-1:0] OP_ADD    = 6'd1;
   localparam logic [ILEN-1:0] OP_SUB    = 6'd2;
   localparam logic [ILEN-1:0] OP_AND    = 6'd3;
   localparam logic [ILEN-1:0] OP_OR     = 6'd4;
   localparam logic [ILEN-1:0] OP_XOR    = 6'd5;
   localparam logic [ILEN-1:0] OP_SLL    = 6'd6;
   localparam logic [ILEN-1:0] OP_SRL    = 6'd7;
   localparam logic [ILEN-1:0] OP_SRA    = 6'd8;
   localparam logic [ILEN-1:0] OP_SLT    = 6'd9;
   localparam logic [ILEN-1:0] OP_SLTU   = 6'd10;
   localparam logic [ILEN-1:0] OP_ADDI   = 6'd11;
   localparam logic [ILEN-1:0] OP_ANDI   = 6'd12;
   localparam logic [ILEN-1:0] OP_ORI    = 6'd13;
   localparam logic [ILEN-1:0] OP_XORI   = 6'd14;
   localparam logic [ILEN-1:0] OP_SLLI   = 6'd15;
   localparam logic [ILEN-1:0] OP_SRLI   = 6'd16;
   localparam logic [ILEN-1:0] OP_SRAI   = 6'd17;
   localparam logic [ILEN-1:0] OP_SLTI   = 6'd18;
   localparam logic [ILEN-1:0] OP_SLTIU  = 6'd19;
   localparam logic [ILEN-1:0] OP_BEQ    = 6'd20;
   localparam logic [ILEN-1:0] OP_BNE    = 6'd21;
   localparam logic [ILEN-1:0] OP_BLT    = 6'd22;
   localparam logic [ILEN-1:0] OP_BGE    = 6'd23;
   localparam logic [ILEN-1:0] OP_BLTU   = 6'd24;
   localparam logic [ILEN-1:0] OP_BGEU   = 6'd25;
   localparam logic [ILEN-1:0] OP_JALR   = 6'd26;
   // M-extension codes are always defined so the decoder can name them;
   // without the multiplier they fall through to the unknown-op result.
   localparam logic [ILEN-1:0] OP_MUL    = 6'd27;
   localparam logic [ILEN-1:0] OP_MULH   = 6'd28;
   localparam logic [ILEN-1:0] OP_MULHSU = 6'd29;
   localparam logic [ILEN-1:0] OP_MULHU  = 6'd30;

   // Multiplier select: 00 low half, 01 signed x signed high,
   // 10 signed x unsigned high, 11 unsigned x unsigned high.
   typedef logic [1:0] mul_sel_t;

   function automatic logic [RLEN-1:0] alu_calc(input logic [ILEN-1:0] op,
                                               input logic [RLEN-1:0] a,
                                               input logic [RLEN-1:0] b);
      logic [RLEN-1:0] r;
      r = '0;
      case (op)
         OP_ADD, OP_ADDI:  r = a + b;
         OP_SUB:           r = a - b;
         OP_AND, OP_ANDI:  r = a & b;
         OP_OR,  OP_ORI:   r = a | b;
         OP_XOR, OP_XORI:  r = a ^ b;
         OP_SLL, OP_SLLI:  r = a << b[4:0];
         OP_SRL, OP_SRLI:  r = a >> b[4:0];
         OP_SRA, OP_SRAI:  r = $signed(a) >>> b[4:0];
         OP_SLT, OP_SLTI:  r = {31'd0, $signed(a) < $signed(b)};
         OP_SLTU, OP_SLTIU: r = {31'd0, a < b};
         OP_BEQ:           r = {31'd0, a == b};
         OP_BNE:           r = {31'd0, a != b};
         OP_BLT:           r = {31'd0, $signed(a) < $signed(b)};
         OP_BGE:           r = {31'd0, $signed(a) >= $signed(b)};
         OP_BLTU:          r = {31'd0, a < b};
         OP_BGEU:          r = {31'd0, a >= b};
         OP_JALR:          r = (a + b) & ~32'd1;
         default:          r = '0;
      endcase
      return r;
   endfunction

   function automatic logic is_mul_op(input logic [ILEN-1:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   endfunction

   function automatic mul_sel_t mul_sel(input logic [ILEN-1:0] op);
      mul_sel_t s;
      case (op)
         OP_MULH:   s = 2'b01;
         OP_MULHSU: s = 2'b10;
         OP_MULHU:  s = 2'b11;
         default:   s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/alu_ex_if.sv
// alu_ex_if: RS issue lines into the ALU and the result broadcast bus out of it.
// master = reservation-station side, slave = alu_ex.
interface alu_ex_if;
   import alu_ex_pkg::*;

   logic            ari_ins_flag;
   logic [ILEN-1:0] ari_insty;
   logic [RLEN-1:0] ari_val1;
   logic [RLEN-1:0] ari_val2;
   logic [RBID-1:0] ari_ROB_idx;
   logic            val_flag_RS;
   logic [RBID-1:0] val_idx_RS;
   logic [RLEN-1:0] val_RS;

   modport master (
      output ari_ins_flag, ari_insty, ari_val1, ari_val2, ari_ROB_idx,
      input  val_flag_RS, val_idx_RS, val_RS
   );

   modport slave (
      input  ari_ins_flag, ari_insty, ari_val1, ari_val2, ari_ROB_idx,
      output val_flag_RS, val_idx_RS, val_RS
   );

endinterface

// File: rtl/alu_ex_mul.sv
// alu_mul: two-stage 32x32 multiplier. The capture edge registers four 16x16
// partial products of the operand magnitudes; the sum, sign fix-up and half
// select are combinational so the product is ready for the next edge.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul
   import alu_ex_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            flush,
   input  logic [RLEN-1:0] a,
   input  logic [RLEN-1:0] b,
   input  mul_sel_t        sel,
   output logic [RLEN-1:0] product
);

   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
   logic        neg_q, hi_q;
   logic [63:0] mag_sum, prod64;

   assign a_neg = (sel == 2'b01 || sel == 2'b10) && a[31];
   assign b_neg = (sel == 2'b01) && b[31];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Capture partial products; a flushed cycle's operands are never used, so skip the update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pp_ll <= '0;
         pp_lh <= '0;
         pp_hl <= '0;
         pp_hh <= '0;
         neg_q <= 1'b0;
         hi_q  <= 1'b0;
      end else if (rdy && !flush) begin
         pp_ll <= {16'd0, a_mag[15:0]}  * {16'd0, b_mag[15:0]};
         pp_lh <= {16'd0, a_mag[15:0]}  * {16'd0, b_mag[31:16]};
         pp_hl <= {16'd0, a_mag[31:16]} * {16'd0, b_mag[15:0]};
         pp_hh <= {16'd0, a_mag[31:16]} * {16'd0, b_mag[31:16]};
         neg_q <= a_neg ^ b_neg;
         hi_q  <= (sel != 2'b00);
      end
   end

   assign mag_sum = {pp_hh, 32'd0} + {16'd0, pp_lh, 16'd0}
                  + {16'd0, pp_hl, 16'd0} + {32'd0, pp_ll};
   assign prod64  = neg_q ? -mag_sum : mag_sum;
   assign product = hi_q ? prod64[63:32] : prod64[31:0];

endmodule

// File: rtl/alu_ex.sv
// alu_ex: integer execution stage downstream of the reservation station.
// Broadcasts {ROB index, result} on the common result bus from a registered
// stage; flushed by jp_wrong, frozen by rdy low.
// Build macro ALU_MUL_EN: adds RV32M via alu_mul and makes every op 2 cycles.
module alu_ex
   import alu_ex_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   input  logic jp_wrong,
   alu_ex_if.slave bus
);

   logic            issue;
   logic [RLEN-1:0] alu_res;
   logic            valid_q;
   logic [RBID-1:0] idx_q;
   logic [RLEN-1:0] value_q;

   // Same condition the RS uses to free its slot, so nothing is ever dropped.
   assign issue   = bus.ari_ins_flag && rdy && !jp_wrong && !rst;
   assign alu_res = alu_calc(bus.ari_insty, bus.ari_val1, bus.ari_val2);

   assign bus.val_flag_RS = valid_q;
   assign bus.val_idx_RS  = idx_q;
   assign bus.val_RS      = value_q;

`ifdef ALU_MUL_EN
   logic            s1_valid;
   logic [RBID-1:0] s1_idx;
   logic [RLEN-1:0] s1_res;
   logic            s1_mul;
   logic [RLEN-1:0] mul_prod;

   alu_mul u_mul (
      .clk     (clk),
      .rst     (rst),
      .rdy     (rdy),
      .flush   (jp_wrong),
      .a       (bus.ari_val1),
      .b       (bus.ari_val2),
      .sel     (mul_sel(bus.ari_insty)),
      .product (mul_prod)
   );

   // Uniform two-stage pipe so ALU and MUL results never contend for the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_res   <= '0;
         s1_mul   <= 1'b0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         value_q  <= '0;
      end else if (jp_wrong) begin
         s1_valid <= 1'b0;
         valid_q  <= 1'b0;
      end else if (rdy) begin
         s1_valid <= issue;
         if (issue) begin
            s1_idx <= bus.ari_ROB_idx;
            s1_res <= alu_res;
            s1_mul <= is_mul_op(bus.ari_insty);
         end
         valid_q <= s1_valid;
         if (s1_valid) begin
            idx_q   <= s1_idx;
            value_q <= s1_mul ? mul_prod : s1_res;
         end
      end
   end
`else
   // Single result register; a flush wins over rdy so a mispredict always clears the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         value_q <= '0;
      end else if (jp_wrong) begin
         valid_q <= 1'b0;
      end else if (rdy) begin
         valid_q <= issue;
         if (issue) begin
            idx_q   <= bus.ari_ROB_idx;
            value_q <= alu_res;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_ex.sv
// tb_alu_ex: directed bench for alu_ex with a scoreboard of expected
// broadcasts (index, value, live-cycle due) checked on the falling edge.
module tb_alu_ex;
   import alu_ex_pkg::*;

`ifdef ALU_MUL_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [RBID-1:0] idx;
      logic [31:0]     val;
      int              due;
   } exp_t;

   typedef struct {
      logic [ILEN-1:0] op;
      logic [31:0]     a;
      logic [31:0]     b;
      logic [31:0]     r;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rdy = 1'b1;
   logic jp_wrong = 1'b0;

   int   checks = 0;
   int   errors = 0;
   int   live = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[$];

   alu_ex_if bus();

   alu_ex dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .jp_wrong (jp_wrong),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Count only edges on which the pipeline advances.
   always @(posedge clk) if (!rst && rdy) live <= live + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [ILEN-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [RBID-1:0] idx);
      bus.ari_ins_flag = 1'b1;
      bus.ari_insty    = op;
      bus.ari_val1     = a;
      bus.ari_val2     = b;
      bus.ari_ROB_idx  = idx;
   endtask

   task automatic expect_res(input logic [RBID-1:0] idx, input logic [31:0] val);
      exp_t e;
      e.idx = idx;
      e.val = val;
      e.due = live + LAT;
      sb.push_back(e);
   endtask

   task automatic idle();
      bus.ari_ins_flag = 1'b0;
   endtask

   // Consumer: takes a broadcast on any falling edge that precedes a rdy-high edge.
   always @(negedge clk) begin
      if (rst === 1'b0 && rdy && bus.val_flag_RS) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_broadcast: observed idx %0d val 0x%08h expected none",
                   bus.val_idx_RS, bus.val_RS);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("bcast_idx", {28'd0, bus.val_idx_RS}, {28'd0, mon_e.idx});
            check("bcast_val", bus.val_RS, mon_e.val);
            check("bcast_cycle", live, mon_e.due);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      bus.ari_insty   = '0;
      bus.ari_val1    = '0;
      bus.ari_val2    = '0;
      bus.ari_ROB_idx = '0;
      #1 rst = 1'b1;
      step();
      step();
      check("rst_flag", {31'd0, bus.val_flag_RS}, 32'd0);
      check("rst_idx", {28'd0, bus.val_idx_RS}, 32'd0);
      check("rst_val", bus.val_RS, 32'd0);

      // Release, issue an op that gets killed by an asynchronous mid-cycle reset.
      rst = 1'b0;
      drive(OP_ADD, 32'd1, 32'd1, 4'd9);
      step();
      #1 rst = 1'b1;
      #1;
      check("async_rst_flag", {31'd0, bus.val_flag_RS}, 32'd0);
      check("async_rst_idx", {28'd0, bus.val_idx_RS}, 32'd0);
      check("async_rst_val", bus.val_RS, 32'd0);
      step();
      rst = 1'b0;
      drive(OP_ADD, 32'd5, 32'd7, 4'd3);
      expect_res(4'd3, 32'd12);
      step();
      idle();
      repeat (LAT + 1) step();
      check("first_add_drained", sb.size(), 32'd0);

      // Back-to-back directed ops.
      vecs.push_back('{OP_SRA,   32'h8000_0000, 32'h0000_0024, 32'hF800_0000});
      vecs.push_back('{OP_SRAI,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF});
      vecs.push_back('{OP_SLTU,  32'd1,         32'hFFFF_FFFF, 32'd1});
      vecs.push_back('{OP_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0});
      vecs.push_back('{OP_BGE,   32'hFFFF_FFFF, 32'd0,         32'd0});
      vecs.push_back('{OP_BGEU,  32'hFFFF_FFFF, 32'd0,         32'd1});
      vecs.push_back('{OP_JALR,  32'h0000_1001, 32'd4,         32'h0000_1004});
      vecs.push_back('{OP_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE});
      vecs.push_back('{OP_XORI,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0});
      vecs.push_back('{OP_SLL,   32'd1,         32'h0000_0021, 32'd2});
      vecs.push_back('{OP_SRLI,  32'h8000_0000, 32'd4,         32'h0800_0000});
      vecs.push_back('{OP_ANDI,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00});
      vecs.push_back('{OP_OR,    32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF});
      vecs.push_back('{OP_ADDI,  32'hFFFF_FFFF, 32'd2,         32'd1});
      vecs.push_back('{OP_BNE,   32'd5,         32'd5,         32'd0});
      vecs.push_back('{OP_BEQ,   32'd5,         32'd5,         32'd1});
      vecs.push_back('{OP_BLT,   32'hFFFF_FFFE, 32'd1,         32'd1});
      vecs.push_back('{OP_BLTU,  32'hFFFF_FFFE, 32'd1,         32'd0});
      vecs.push_back('{6'h3F,    32'd9,         32'd9,         32'd0});
`ifdef ALU_MUL_EN
      vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
      vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'd2,         32'd1});
      vecs.push_back('{OP_MUL,    32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD});
      vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF});
      vecs.push_back('{OP_ADD,    32'd10,        32'd20,        32'd30});
`else
      vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'd0});
      vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'd2,         32'd0});
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
         expect_res(4'(i), vecs[i].r);
         step();
      end
      idle();
      repeat (LAT + 2) step();
      check("vec_drained", sb.size(), 32'd0);

      // Three consecutive issues, no flush.
      for (int i = 1; i <= 3; i++) begin
         drive(OP_ADD, 32'(i), 32'd100, 4'(i));
         expect_res(4'(i), 32'(i + 100));
         step();
      end
      idle();
      repeat (LAT + 2) step();
      check("b2b_drained", sb.size(), 32'd0);

      // Mispredict on the edge after the second issue.
      drive(OP_ADD, 32'd1, 32'd1, 4'd1);
      expect_res(4'd1, 32'd2);
      step();
      drive(OP_ADD, 32'd2, 32'd2, 4'd2);
`ifndef ALU_MUL_EN
      expect_res(4'd2, 32'd4);
`endif
      step();
      drive(OP_ADD, 32'd3, 32'd3, 4'd3);
      jp_wrong = 1'b1;
      step();
      jp_wrong = 1'b0;
      idle();
      @(negedge clk);
      check("flush_flag", {31'd0, bus.val_flag_RS}, 32'd0);
      step();
      repeat (3) step();
      check("flush_drained", sb.size(), 32'd0);

      // rdy low for four edges while a result sits on the bus.
      drive(OP_ADD, 32'h0000_0100, 32'h0000_0023, 4'd7);
      expect_res(4'd7, 32'h0000_0123);
      step();
      idle();
      repeat (LAT - 1) step();
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_flag", {31'd0, bus.val_flag_RS}, 32'd1);
         check("hold_idx", {28'd0, bus.val_idx_RS}, 32'd7);
         check("hold_val", bus.val_RS, 32'h0000_0123);
      end
      step();
      rdy = 1'b1;
      step();
      @(negedge clk);
      check("rdy_release_drop", {31'd0, bus.val_flag_RS}, 32'd0);
      step();
      check("final_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
